// File: rtl/toggle_ff_bank.sv
// Purpose : bank of CHANNELS run-time configurable flip-flops (T-level, T-edge, D, hold)
//           with optional input synchroniser, per-channel wrapping transition counters
//           and a registered aggregate toggle flag.
// Latency : in_bits -> q is SYNC_STAGES+1 clock edges; counters/any_toggle update with q.
// Backpressure: none; every input is sampled every cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_bits         per-channel data/toggle inputs (may be asynchronous when SYNC_STAGES>0)
//   cfg_we/ch/mode  per-channel mode write (0 T-level, 1 T-edge, 2 D, 3 hold)
//   load/load_val   parallel preload of q, overrides mode behaviour for that cycle
//   q, qbar         flip-flop state and its complement
//   toggle_cnt      channel i counter in bits [i*COUNT_W +: COUNT_W]
//   any_toggle      high in the cycle after an edge where any q bit changed by mode behaviour
module toggle_ff_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         in_bits,
  input  logic                        cfg_we,
  input  logic [CH_W-1:0]             cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic                        load,
  input  logic [CHANNELS-1:0]         load_val,
  output logic [CHANNELS-1:0]         q,
  output logic [CHANNELS-1:0]         qbar,
  output logic [CHANNELS*COUNT_W-1:0] toggle_cnt,
  output logic                        any_toggle
);

  typedef enum logic [1:0] {
    MODE_T_LEVEL = 2'd0,
    MODE_T_EDGE  = 2'd1,
    MODE_D       = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  // One extra bit so CHANNELS itself is representable for the range check.
  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic [CHANNELS-1:0]              w_s;
  logic [CHANNELS-1:0]              w_edge;
  logic [CHANNELS-1:0]              w_q_nxt;
  logic [CHANNELS-1:0]              w_chg;
  logic                             w_cfg_hit;

  logic [CHANNELS-1:0]              r_q;
  logic [CHANNELS-1:0]              r_prev;
  logic                             r_any;
  logic [CHANNELS-1:0][COUNT_W-1:0] r_cnt;
  mode_e                            r_mode [CHANNELS];

  // Input synchroniser; zero stages passes the inputs straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = in_bits;
    end else begin : g_sync
      logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
          end
        end else begin
          r_sync[0] <= in_bits;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Mode behaviour: next q per channel, evaluated with the mode currently stored.
  always_comb begin
    w_edge  = w_s & ~r_prev;
    w_q_nxt = r_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (r_mode[i])
        MODE_T_LEVEL: if (w_s[i])    w_q_nxt[i] = ~r_q[i];
        MODE_T_EDGE:  if (w_edge[i]) w_q_nxt[i] = ~r_q[i];
        MODE_D:       w_q_nxt[i] = w_s[i];
        MODE_HOLD:    w_q_nxt[i] = r_q[i];
        default:      w_q_nxt[i] = r_q[i];
      endcase
    end
    // A D-mode write of the same value leaves this bit clear, so it is not counted.
    w_chg = w_q_nxt ^ r_q;
  end

  // Writes to non-existent channels are dropped.
  assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
      r_any  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_mode[k] <= MODE_T_LEVEL;
      end
    end else begin
      // Edge history advances even on load cycles, so an edge seen during load is lost.
      r_prev <= w_s;
      if (load) begin
        r_q   <= load_val;
        r_any <= 1'b0;
      end else begin
        r_q   <= w_q_nxt;
        r_any <= |w_chg;
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_chg[i]) begin
            r_cnt[i] <= r_cnt[i] + COUNT_W'(1);
          end
        end
      end
      // The new mode takes effect from the following edge; this edge used the old one.
      if (w_cfg_hit) begin
        r_mode[cfg_ch] <= mode_e'(cfg_mode);
      end
    end
  end

  assign q          = r_q;
  assign qbar       = ~r_q;
  assign toggle_cnt = r_cnt;
  assign any_toggle = r_any;

endmodule
